// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg
// Shared definitions for the memory fill arbiter:
//   - fill_state_e : controller FSM state encoding
//   - PRIO_FIXED / PRIO_RR : arbitration mode selectors
//   - WORD_BYTES : bytes per memory word (address stride within a line)
//   - oh2idx() : index of the highest set bit of a one-hot vector
package mem_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WRITE = 2'd3
  } fill_state_e;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  localparam int WORD_BYTES = 2;

  // Returns the position of the set bit of a one-hot vector (0 if none).
  function automatic int oh2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// mem_fill_arbiter_if
// Pipelined memory bus between the fill arbiter (master) and the
// multicycle memory (slave).
//   mem_en     : access enable, one access issued per cycle it is high
//   mem_wr     : 1 = write, 0 = read
//   mem_addr   : byte address
//   mem_wdata  : store data
//   mem_rdata  : read data, valid with mem_rvalid
//   mem_rvalid : read return strobe; returns arrive in issue order
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/mem_fill_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational request picker with an internal round-robin pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   pending_i  : per-channel pending requests
//   served_i   : one-hot channel whose service is completing
//   advance_i  : pointer moves to index(served_i)+1 (mod N_CH) when high
//   winner_o   : one-hot winner, all zero when nothing is pending
// PRIO_MODE selects fixed priority (highest index wins) or round robin
// (first pending index at or above the pointer, wrapping).
module rr_arbiter
  import mem_fill_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int PRIO_MODE = PRIO_FIXED
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pending_i,
  input  logic [N_CH-1:0] served_i,
  input  logic            advance_i,
  output logic [N_CH-1:0] winner_o
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    logic found;
    winner_o = '0;
    found    = 1'b0;
    if (PRIO_MODE == PRIO_RR) begin
      // First pass covers indices at/above the pointer; the second pass
      // handles the wrap, where only indices below the pointer can match.
      for (int i = 0; i < N_CH; i++) begin
        if (!found && (i >= int'(ptr_q)) && pending_i[i]) begin
          winner_o[i] = 1'b1;
          found       = 1'b1;
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!found && pending_i[i]) begin
          winner_o[i] = 1'b1;
          found       = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (pending_i[i]) begin
          winner_o    = '0;
          winner_o[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d = PTR_W'((oh2idx(32'(served_i)) + 1) % N_CH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter
// Arbitrates cache-line fills and single-word write-through stores from
// N_CH requestors onto one pipelined multicycle memory.
//   clk, rst_n    : clock, asynchronous active-low reset
//   req_i         : per-channel line-fill request, held until done
//   wr_req_i      : per-channel write-through request, held until done
//   req_addr_i    : per-channel byte address ([i*ADDR_W +: ADDR_W])
//   wr_data_i     : per-channel store data ([i*DATA_W +: DATA_W])
//   grant_o       : registered one-hot channel being served
//   fill_we_o     : data-array write strobe towards the granted channel
//   fill_word_o   : word offset within the line for fill_we_o
//   fill_data_o   : returned word (mem_rdata while fill_we_o is active)
//   done_o        : one-cycle completion pulse for the granted channel
//   mem_bus       : memory master port (see mem_fill_arbiter_if)
// A fill issues LINE_WORDS back-to-back reads, then waits for the
// remaining returns; a write is a single cycle. Writes take precedence
// over a fill pending on the same channel.
module mem_fill_arbiter
  import mem_fill_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int PRIO_MODE  = PRIO_FIXED
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               req_i,
  input  logic [N_CH-1:0]               wr_req_i,
  input  logic [N_CH*ADDR_W-1:0]        req_addr_i,
  input  logic [N_CH*DATA_W-1:0]        wr_data_i,
  output logic [N_CH-1:0]               grant_o,
  output logic [N_CH-1:0]               fill_we_o,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word_o,
  output logic [DATA_W-1:0]             fill_data_o,
  output logic [N_CH-1:0]               done_o,
  mem_fill_arbiter_if.master            mem_bus
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
  // Clears the word offset and the byte-in-word bit.
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~(ADDR_W'((1 << (WORD_W + 1)) - 1));

  fill_state_e       state_q;
  logic [N_CH-1:0]   grant_q;
  logic [WORD_W-1:0] issue_cnt_q;
  logic [WORD_W-1:0] ret_cnt_q;
  logic              mem_en_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [N_CH-1:0]   pending;
  logic [N_CH-1:0]   win_oh;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              ret_accept;
  logic              ret_last;

  assign pending = req_i | wr_req_i;

  rr_arbiter #(
    .N_CH      (N_CH),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .pending_i (pending),
    .served_i  (grant_q),
    .advance_i (|done_o),
    .winner_o  (win_oh)
  );

  // Select the winner's address, store data and write request.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (win_oh[i]) begin
        win_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        win_wdata = wr_data_i[i*DATA_W +: DATA_W];
      end
    end
    win_wr = |(wr_req_i & win_oh);
  end

  // Returns count only while a fill is in flight; anything seen in IDLE
  // or WRITE (including stale returns after a reset) is dropped.
  assign ret_accept = mem_bus.mem_rvalid &&
                      ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign ret_last   = ret_accept && (ret_cnt_q == LAST_WORD);

  assign grant_o     = grant_q;
  assign fill_we_o   = ret_accept ? grant_q : '0;
  assign fill_word_o = ret_accept ? ret_cnt_q : '0;
  assign fill_data_o = ret_accept ? mem_bus.mem_rdata : '0;
  assign done_o      = ((state_q == ST_WRITE) || ret_last) ? grant_q : '0;

  assign mem_bus.mem_en    = mem_en_q;
  assign mem_bus.mem_wr    = mem_wr_q;
  assign mem_bus.mem_addr  = mem_addr_q;
  assign mem_bus.mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|pending) begin
            grant_q     <= win_oh;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mem_en_q    <= 1'b1;
            if (win_wr) begin
              state_q     <= ST_WRITE;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= win_addr;
              mem_wdata_q <= win_wdata;
            end else begin
              state_q     <= ST_ISSUE;
              mem_wr_q    <= 1'b0;
              mem_addr_q  <= win_addr & LINE_MASK;
            end
          end
        end

        ST_ISSUE: begin
          if (ret_accept) ret_cnt_q <= ret_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_WORD) begin
            state_q     <= ST_DRAIN;
            issue_cnt_q <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
          end else begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(WORD_BYTES);
          end
          // Very short memory latency can complete the line before the
          // issue phase ends; completion overrides the issue bookkeeping.
          if (ret_last) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
          end
        end

        ST_DRAIN: begin
          if (ret_accept) ret_cnt_q <= ret_cnt_q + 1'b1;
          if (ret_last) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ret_cnt_q <= '0;
          end
        end

        ST_WRITE: begin
          state_q     <= ST_IDLE;
          grant_q     <= '0;
          mem_en_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter: a 2-channel fixed-priority
// instance (line 8 words, memory latency 4) and a 4-channel round-robin
// instance (line 4 words, memory latency 2), each with a small read
// pipeline model whose data is a fixed function of the address.
module tb_mem_fill_arbiter;
  import mem_fill_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // ---------------- instance A: N_CH=2, fixed, LINE_WORDS=8, latency 4
  logic [1:0]  req_a, wr_req_a, grant_a, fill_we_a, done_a;
  logic [31:0] req_addr_a, wr_data_a;
  logic [2:0]  fill_word_a;
  logic [15:0] fill_data_a;
  logic        force_rv_a;
  logic [3:0]  vp_a = '0;
  logic [15:0] ap_a [4] = '{default: 16'h0};

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_a ();

  mem_fill_arbiter #(
    .N_CH(2), .ADDR_W(16), .DATA_W(16), .LINE_WORDS(8), .PRIO_MODE(PRIO_FIXED)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .wr_req_i(wr_req_a),
    .req_addr_i(req_addr_a), .wr_data_i(wr_data_a), .grant_o(grant_a),
    .fill_we_o(fill_we_a), .fill_word_o(fill_word_a), .fill_data_o(fill_data_a),
    .done_o(done_a), .mem_bus(bus_a)
  );

  always @(posedge clk) begin
    vp_a    <= {vp_a[2:0], bus_a.mem_en & ~bus_a.mem_wr};
    ap_a[0] <= bus_a.mem_addr;
    for (int i = 1; i < 4; i++) ap_a[i] <= ap_a[i-1];
  end
  assign bus_a.mem_rvalid = vp_a[3] | force_rv_a;
  assign bus_a.mem_rdata  = mdat(ap_a[3]);

  // ---------------- instance B: N_CH=4, round robin, LINE_WORDS=4, latency 2
  logic [3:0]  req_b, wr_req_b, grant_b, fill_we_b, done_b;
  logic [63:0] req_addr_b, wr_data_b;
  logic [1:0]  fill_word_b;
  logic [15:0] fill_data_b;
  logic [1:0]  vp_b = '0;
  logic [15:0] ap_b [2] = '{default: 16'h0};

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_b ();

  mem_fill_arbiter #(
    .N_CH(4), .ADDR_W(16), .DATA_W(16), .LINE_WORDS(4), .PRIO_MODE(PRIO_RR)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .wr_req_i(wr_req_b),
    .req_addr_i(req_addr_b), .wr_data_i(wr_data_b), .grant_o(grant_b),
    .fill_we_o(fill_we_b), .fill_word_o(fill_word_b), .fill_data_o(fill_data_b),
    .done_o(done_b), .mem_bus(bus_b)
  );

  always @(posedge clk) begin
    vp_b    <= {vp_b[0], bus_b.mem_en & ~bus_b.mem_wr};
    ap_b[0] <= bus_b.mem_addr;
    ap_b[1] <= ap_b[0];
  end
  assign bus_b.mem_rvalid = vp_b[1];
  assign bus_b.mem_rdata  = mdat(ap_b[1]);

  // Full line fill on instance A; request driven in cycle t, observed
  // at cycle t+n: issues n=1..8, returns n=5..12, done at n=12.
  task automatic fill_a(input int ch, input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    req_addr_a[ch*16 +: 16] = addr;
    req_a[ch] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        chk("issue_en", bus_a.mem_en, 1);
        chk("issue_rd", bus_a.mem_wr, 0);
        chk("issue_addr", bus_a.mem_addr, base + 2*(n-1));
      end
      if (n == 9) chk("issue_stop", bus_a.mem_en, 0);
      if (n >= 5 && n <= 12) begin
        chk("fill_we", fill_we_a, 1 << ch);
        chk("fill_word", fill_word_a, n - 5);
        chk("fill_data", fill_data_a, mdat(base + 16'(2*(n-5))));
      end else begin
        chk("fill_we_idle", fill_we_a, 0);
      end
      chk("fill_done", done_a, (n == 12) ? (1 << ch) : 0);
      chk("fill_grant", grant_a, (n <= 12) ? (1 << ch) : 0);
      if (n == 12) req_a[ch] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int multihot, gap, got, cnt;
    bit seen1, seen0, started0, found;
    logic [3:0] prev;
    logic [3:0] seq [5];

    rst_n = 1'b0;
    req_a = '0; wr_req_a = '0; req_addr_a = '0; wr_data_a = '0; force_rv_a = 1'b0;
    req_b = '0; wr_req_b = '0; req_addr_b = '0; wr_data_b = '0;
    #1;
    chk("rst_grant", grant_a, 0);
    chk("rst_fill_we", fill_we_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_mem_en", bus_a.mem_en, 0);
    chk("rst_mem_wr", bus_a.mem_wr, 0);
    chk("rst_mem_addr", bus_a.mem_addr, 0);
    chk("rst_mem_wdata", bus_a.mem_wdata, 0);
    chk("rst_grant_b", grant_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // rvalid pulse while idle must be ignored
    @(negedge clk);
    force_rv_a = 1'b1;
    #1;
    chk("idle_rv_we", fill_we_a, 0);
    chk("idle_rv_done", done_a, 0);
    @(negedge clk);
    force_rv_a = 1'b0;
    chk("idle_rv_grant", grant_a, 0);
    chk("idle_rv_mem_en", bus_a.mem_en, 0);

    // basic fill, unaligned address 0x0013
    fill_a(0, 16'h0013);

    // fixed priority: both channels at once
    req_addr_a = {16'h0200, 16'h0100};
    req_a = 2'b11;
    multihot = 0; gap = 0; seen1 = 0; seen0 = 0; started0 = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("prio_first", grant_a, 2'b10);
        chk("prio_first_addr", bus_a.mem_addr, 16'h0200);
      end
      if (grant_a == 2'b11) multihot++;
      if (done_a[1]) begin
        req_a[1] = 1'b0;
        seen1 = 1;
      end else if (seen1 && !started0 && grant_a == 2'b00) begin
        gap++;
      end
      if (seen1 && !started0 && grant_a == 2'b01) begin
        started0 = 1;
        chk("prio_second_addr", bus_a.mem_addr, 16'h0100);
      end
      if (done_a[0]) begin
        req_a[0] = 1'b0;
        seen0 = 1;
        break;
      end
    end
    chk("prio_multihot", multihot, 0);
    chk("prio_done1", seen1, 1);
    chk("prio_started0", started0, 1);
    chk("prio_done0", seen0, 1);
    chk("prio_gap", gap, 1);
    @(negedge clk);

    // single write on channel 1
    req_addr_a[31:16] = 16'h0041;
    wr_data_a[31:16]  = 16'hBEEF;
    wr_req_a = 2'b10;
    @(negedge clk);
    chk("wr_en", bus_a.mem_en, 1);
    chk("wr_wr", bus_a.mem_wr, 1);
    chk("wr_addr", bus_a.mem_addr, 16'h0041);
    chk("wr_data", bus_a.mem_wdata, 16'hBEEF);
    chk("wr_done", done_a, 2'b10);
    chk("wr_grant", grant_a, 2'b10);
    chk("wr_no_fill", fill_we_a, 0);
    wr_req_a = 2'b00;
    @(negedge clk);
    chk("wr_after_en", bus_a.mem_en, 0);
    chk("wr_after_done", done_a, 0);
    chk("wr_after_grant", grant_a, 0);

    // write and fill pending together on one channel: write first
    wr_req_a = 2'b10;
    req_a    = 2'b10;
    @(negedge clk);
    chk("wf_write_first", bus_a.mem_wr, 1);
    chk("wf_write_done", done_a, 2'b10);
    wr_req_a = 2'b00;
    @(negedge clk);
    chk("wf_idle_gap", grant_a, 0);
    @(negedge clk);
    chk("wf_fill_grant", grant_a, 2'b10);
    chk("wf_fill_rd", bus_a.mem_wr, 0);
    chk("wf_fill_addr", bus_a.mem_addr, 16'h0040);
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_a[1]) begin
        found = 1;
        break;
      end
    end
    chk("wf_fill_done", found, 1);
    req_a = 2'b00;
    @(negedge clk);

    // reset after the 3rd returned word
    req_addr_a[15:0] = 16'h0080;
    req_a = 2'b01;
    for (int n = 1; n <= 7; n++) @(negedge clk);
    chk("mid_3rd_we", fill_we_a, 2'b01);
    chk("mid_3rd_word", fill_word_a, 2);
    rst_n = 1'b0;
    req_a = 2'b00;
    #1;
    chk("mid_rst_grant", grant_a, 0);
    chk("mid_rst_we", fill_we_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_mem_en", bus_a.mem_en, 0);
    chk("mid_rst_mem_addr", bus_a.mem_addr, 0);
    chk("mid_rst_word", fill_word_a, 0);
    chk("mid_rst_data", fill_data_a, 0);
    for (int n = 8; n <= 12; n++) begin
      @(negedge clk);
      rst_n = 1'b1;
      chk("stale_we", fill_we_a, 0);
      chk("stale_done", done_a, 0);
    end
    fill_a(0, 16'h0080);

    // round robin on instance B, all requests held
    for (int i = 0; i < 5; i++) seq[i] = '0;
    prev = '0; got = 0; multihot = 0;
    req_b = 4'hF;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if ($countones(grant_b) > 1) multihot++;
      if (grant_b != 4'h0 && prev == 4'h0 && got < 5) begin
        seq[got] = grant_b;
        got++;
      end
      prev = grant_b;
      if (got == 5) break;
    end
    // drop every request; the channel-0 service already started must finish
    req_b = 4'h0;
    chk("rr_count", got, 5);
    chk("rr_g0", seq[0], 4'b0001);
    chk("rr_g1", seq[1], 4'b0010);
    chk("rr_g2", seq[2], 4'b0100);
    chk("rr_g3", seq[3], 4'b1000);
    chk("rr_g4", seq[4], 4'b0001);
    cnt = 0; found = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if ($countones(grant_b) > 1) multihot++;
      if (fill_we_b[0]) cnt++;
      if (done_b[0]) begin
        found = 1;
        break;
      end
    end
    chk("rr_multihot", multihot, 0);
    chk("rr_drop_done", found, 1);
    chk("rr_drop_words", cnt, 4);
    @(negedge clk);
    chk("rr_end_grant", grant_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
Parametrised shared-memory controller that arbitrates cache misses from N_CH requestors (I-cache, D-cache, and later more) onto one pipelined multicycle memory. It serves whole-line fills word by word and single-word write-through stores. It strobes returned words into the granted cache's data array and pulses a per-channel done. It sits between the cache top level and the multicycle memory, and generalises the fixed two-port I/D fill path with a configurable channel count, line size and arbitration mode.

Parameters:
N_CH, 2, number of requesting channels; channel N_CH-1 is the D-cache.
ADDR_W, 16, byte address width.
DATA_W, 16, word width; word size is 2 bytes.
LINE_WORDS, 8, words per cache line; must be a power of 2, at least 2.
PRIO_MODE, 0, 0 = fixed priority (highest index wins), 1 = round robin.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req  in  N_CH  line-fill request per channel; held until done
wr_req  in  N_CH  single-word write-through request; held until done
req_addr  in  N_CH*ADDR_W  byte address per channel (channel i in bits [i*ADDR_W +: ADDR_W])
wr_data  in  N_CH*DATA_W  store data per channel
grant  out  N_CH  one-hot, registered; channel currently being served
fill_we  out  N_CH  data-array write strobe to the granted channel
fill_word  out  log2(LINE_WORDS)  word offset within the line for fill_we
fill_data  out  DATA_W  word to write (equals mem_rdata)
done  out  N_CH  one-cycle completion pulse
mem_en  out  1  memory access enable
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  read data
mem_rvalid  in  1  mem_rdata valid; returns in issue order

Behaviour:
- Reset is asynchronous and active-low: FSM goes to IDLE, counters and RR pointer go to 0, and every output is 0 immediately.
- FSM states: IDLE, ISSUE, DRAIN, WRITE. Encodings come from the package.
- IDLE: pending = req | wr_req. If nonzero, the arbiter picks a winner, registers the one-hot grant, and moves to WRITE if wr_req[winner] is set, otherwise to ISSUE. If the winner has both req and wr_req set, the write is served first and the fill stays pending.
- Fixed mode: highest pending index wins. RR mode: the first pending index at or above the pointer wins, wrapping around. The pointer becomes winner+1 (mod N_CH) when done pulses.
- ISSUE: lasts exactly LINE_WORDS cycles. Each cycle drives mem_en=1, mem_wr=0, mem_addr = line_base + 2*issue_cnt, where line_base = req_addr with low log2(LINE_WORDS)+1 bits cleared. No address wrap occurs within a line. After the last issue, go to DRAIN.
- Returns during ISSUE or DRAIN: each mem_rvalid drives fill_we = grant, fill_word = ret_cnt, fill_data = mem_rdata (combinational from mem_rdata), then ret_cnt increments.
- Fill completion: the rvalid with ret_cnt == LINE_WORDS-1 also drives done = grant in the same cycle. The FSM then returns to IDLE, grant clears next cycle, and counters reset. If that final rvalid arrives while still in ISSUE, completion happens the same way.
- WRITE: one cycle with mem_en=1, mem_wr=1, mem_addr = req_addr (unaligned low bit passed through), mem_wdata = wr_data[winner], done = grant. Then return to IDLE.
- Latency: with request first seen in IDLE at cycle t and memory latency L, a fill's done occurs at t+LINE_WORDS+L. A write's done occurs at t+1.
- Request dropped mid-service: ignored; service runs to completion.
- mem_rvalid while in IDLE or WRITE: ignored, no fill_we. This covers stale returns after a reset.
- Once granted, a channel cannot be preempted. grant is never multi-hot. fill_we is nonzero only on the granted bit.
- Reset mid-fill: abandons the fill. A re-issued request restarts at word 0.

Decomposition:
- Package mem_fill_pkg holds the state encoding (ST_IDLE, ST_ISSUE, ST_DRAIN, ST_WRITE), the PRIO_FIXED/PRIO_RR constants, and the word byte size (2).
- Sub-module rr_arbiter(N_CH, PRIO_MODE) takes pending, pointer and an advance input, and returns a one-hot winner. It is combinational, and the pointer register lives inside it.

Test Plan:
1. Fill: N_CH=2, LINE_WORDS=8, memory latency 4, req[0] with addr 0x0013 → mem_addr 0x0010,0x0012,…,0x001E on 8 consecutive cycles; 8 fill_we[0] pulses with fill_word 0..7 carrying model data; a single done[0] pulse at t+12.
2. Fixed priority: req[0] and req[1] asserted in the same cycle → channel 1 is served fully, then channel 0; grant never 2'b11 and never 2'b00 between back-to-back services except the one IDLE cycle.
3. Round robin, N_CH=4, all req held continuously → grant sequence 0,1,2,3,0.
4. Write: wr_req[1], addr 0x0041, data 0xBEEF → exactly one cycle with mem_en=1, mem_wr=1, mem_addr=0x0041, mem_wdata=0xBEEF, done[1]=1; no fill_we.
5. Reset asserted after the 3rd returned word → all outputs 0 asynchronously; later stale rvalids produce no fill_we; re-request refills words 0..7 from scratch.
6. mem_rvalid pulsed in IDLE → no fill_we, no done, state stays IDLE.
